// File: rtl/inst_fetch_pkg.sv
// Shared widths and the fetch queue entry layout for the NECPU fetch stage.
// The optional zero-word halt is selected with the FETCH_HALT_ZERO_EN macro.
package inst_fetch_pkg;

  localparam int INST_BUS_WIDTH = 32;
  localparam int INST_ADDR_BUS  = 32;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0]  pc;
    logic [INST_BUS_WIDTH-1:0] inst;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Register-output FIFO for fetched {pc, inst} pairs.
// Flush beats push; a push into a full queue is only taken when a pop frees a slot.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[head_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + PW'(1);
      end
      if (do_pop) begin
        head_d = head_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Queue state registers; reset empties the queue at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// NECPU fetch stage: owns the PC, addresses the combinational instMem and
// queues {pc, inst} pairs towards decode. Redirect flushes and reloads the PC.
// Define FETCH_HALT_ZERO_EN to stop fetching on an all-zero instruction word.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = '0,
  parameter int                       DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [INST_ADDR_BUS-1:0]  imem_addr,
  input  logic [INST_BUS_WIDTH-1:0] imem_inst,
  output logic                      if_valid,
  input  logic                      if_ready,
  output logic [INST_BUS_WIDTH-1:0] if_inst,
  output logic [INST_ADDR_BUS-1:0]  if_pc,
  input  logic                      redirect_valid,
  input  logic [INST_ADDR_BUS-1:0]  redirect_pc,
  output logic                      halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [INST_ADDR_BUS-1:0] pc_q, pc_d;
  logic                     pop, fetch, push, zero_word;
  logic                     q_full, q_empty;
  // Occupancy is available from the queue but fetch only needs full/empty.
  logic [CW-1:0]            q_count_unused;
  fetch_entry_t             q_din, q_dout;

  assign imem_addr = pc_q;
  assign pop       = if_valid & if_ready;
  assign if_valid  = ~q_empty;
  assign if_pc     = q_dout.pc;
  assign if_inst   = q_dout.inst;
  assign q_din     = '{pc: pc_q, inst: imem_inst};

  // Fetch/redirect decision and next PC.
  always_comb begin
    zero_word = 1'b0;
`ifdef FETCH_HALT_ZERO_EN
    zero_word = (imem_inst == '0);
`endif
    fetch = ~redirect_valid & ~halted & (~q_full | pop);
    push  = fetch & ~zero_word;
    pc_d  = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + INST_ADDR_BUS'(1);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

`ifdef FETCH_HALT_ZERO_EN
  logic halted_q, halted_d;

  assign halted = halted_q;

  // Halt sets on a fetched zero word; only a redirect clears it.
  always_comb begin
    halted_d = halted_q;
    if (redirect_valid)          halted_d = 1'b0;
    else if (fetch && zero_word) halted_d = 1'b1;
  end

  // Halt flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`else
  assign halted = 1'b0;
`endif

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count_unused),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule
